// File: rtl/or1200_icpu_imem.sv
// Instruction-memory slave for the or1200 icpu fetch port.
// Serves 32-bit words after a fixed number of wait states, flags misaligned
// or out-of-range fetches with an error pulse, and offers a side-band
// preload port for filling the array before the CPU is released.
module or1200_icpu_imem #(
  parameter int          AW          = 10,
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   icpu_adr_o,
  input  logic          icpu_cycstb_o,
  input  logic [3:0]    icpu_sel_o,
  input  logic [3:0]    icpu_tag_o,
  output logic [31:0]   icpu_dat_i,
  output logic          icpu_ack_i,
  output logic          icpu_rty_i,
  output logic          icpu_err_i,
  output logic [31:0]   icpu_adr_i,
  output logic [3:0]    icpu_tag_i,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_adr,
  input  logic [31:0]   ld_dat
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // One past the last mapped byte, kept 33 bits wide so the top of the
  // 32-bit address space cannot wrap the comparison.
  localparam logic [32:0] TOP_ADR = {1'b0, BASE_ADR} + (33'd4 << AW);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     adr_q, adr_d;
  logic [3:0]      tag_q, tag_d;
  logic            errp_q, errp_d;
  logic [AW-1:0]   idx_q, idx_d;

  logic [31:0]     dat_q;
  logic            ack_q;
  logic            err_q;
  logic [31:0]     radr_q;
  logic [3:0]      rtag_q;

  logic [31:0]     mem [2**AW];

  logic [31:0]     offset;
  logic            decode_err;
  logic            unused_bits;

  assign offset     = icpu_adr_o - BASE_ADR;
  assign decode_err = (icpu_adr_o[1:0] != 2'b00)
                   || (icpu_adr_o < BASE_ADR)
                   || ({1'b0, icpu_adr_o} >= TOP_ADR);

  // Byte selects are meaningless for a word-only instruction memory, and the
  // high offset bits are only reachable on fetches already flagged as errors.
  assign unused_bits = ^{icpu_sel_o, offset};

  assign icpu_dat_i = dat_q;
  assign icpu_ack_i = ack_q;
  assign icpu_err_i = err_q;
  assign icpu_rty_i = 1'b0;
  assign icpu_adr_i = radr_q;
  assign icpu_tag_i = rtag_q;

  // Next-state logic: accept in IDLE, count down wait states, respond once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    tag_d   = tag_q;
    errp_d  = errp_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (icpu_cycstb_o) begin
          adr_d   = icpu_adr_o;
          tag_d   = icpu_tag_o;
          errp_d  = decode_err;
          idx_d   = offset[AW+1:2];
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!icpu_cycstb_o) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Transaction state register; the latched request survives until replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= 32'd0;
      tag_q   <= 4'd0;
      errp_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      tag_q   <= tag_d;
      errp_q  <= errp_d;
      idx_q   <= idx_d;
    end
  end

  // Response register: synchronous memory read in the RESP cycle, one-cycle
  // ack or err pulse, and address/tag echo that holds until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_q  <= 32'd0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      radr_q <= 32'd0;
      rtag_q <= 4'd0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (state_q == RESP) begin
        radr_q <= adr_q;
        rtag_q <= tag_q;
        if (errp_q) begin
          err_q <= 1'b1;
          dat_q <= 32'd0;
        end else begin
          ack_q <= 1'b1;
          dat_q <= mem[idx_q];
        end
      end
    end
  end

  // Preload write port; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_adr] <= ld_dat;
    end
  end

endmodule

// File: tb/tb_or1200_icpu_imem.sv
// Directed bench for or1200_icpu_imem: one instance with one wait state and
// one with three wait states share the address, tag and preload buses.
module tb_or1200_icpu_imem;

  logic        clk;
  logic        rst_n;
  logic [31:0] adr;
  logic [3:0]  tag;
  logic [3:0]  sel;
  logic        cyc1;
  logic        cyc3;
  logic        ld_we;
  logic [9:0]  ld_adr;
  logic [31:0] ld_dat;

  logic [31:0] dat1, adri1, dat3, adri3;
  logic        ack1, rty1, err1, ack3, rty3, err3;
  logic [3:0]  tagi1, tagi3;

  int checks;
  int errors;

  or1200_icpu_imem #(.AW(10), .BASE_ADR(32'h0), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .icpu_adr_o(adr), .icpu_cycstb_o(cyc1), .icpu_sel_o(sel), .icpu_tag_o(tag),
    .icpu_dat_i(dat1), .icpu_ack_i(ack1), .icpu_rty_i(rty1), .icpu_err_i(err1),
    .icpu_adr_i(adri1), .icpu_tag_i(tagi1),
    .ld_we(ld_we), .ld_adr(ld_adr), .ld_dat(ld_dat)
  );

  or1200_icpu_imem #(.AW(10), .BASE_ADR(32'h0), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .icpu_adr_o(adr), .icpu_cycstb_o(cyc3), .icpu_sel_o(sel), .icpu_tag_o(tag),
    .icpu_dat_i(dat3), .icpu_ack_i(ack3), .icpu_rty_i(rty3), .icpu_err_i(err3),
    .icpu_adr_i(adri3), .icpu_tag_i(tagi3),
    .ld_we(ld_we), .ld_adr(ld_adr), .ld_dat(ld_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_we  = 1'b1;
    ld_adr = a;
    ld_dat = d;
    @(negedge clk);
    ld_we  = 1'b0;
  endtask

  // Single fetch on the one-wait-state instance; the response is expected
  // on the second edge after the request is sampled.
  task automatic fetch1(input string name, input logic [31:0] a, input logic [3:0] t,
                        input logic exp_ack, input logic [31:0] exp_dat);
    @(negedge clk);
    cyc1 = 1'b1;
    adr  = a;
    tag  = t;
    @(negedge clk);
    chk({name, ".ack_e0"}, 32'(ack1), 32'd0);
    chk({name, ".err_e0"}, 32'(err1), 32'd0);
    @(negedge clk);
    chk({name, ".ack_e1"}, 32'(ack1), 32'd0);
    cyc1 = 1'b0;
    @(negedge clk);
    chk({name, ".ack"}, 32'(ack1), 32'(exp_ack));
    chk({name, ".err"}, 32'(err1), 32'(!exp_ack));
    chk({name, ".dat"}, dat1, exp_dat);
    chk({name, ".adr"}, adri1, a);
    chk({name, ".tag"}, 32'(tagi1), 32'(t));
    @(negedge clk);
    chk({name, ".ack_off"}, 32'(ack1), 32'd0);
    chk({name, ".err_off"}, 32'(err1), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    adr    = 32'd0;
    tag    = 4'd0;
    sel    = 4'hF;
    cyc1   = 1'b0;
    cyc3   = 1'b0;
    ld_we  = 1'b0;
    ld_adr = 10'd0;
    ld_dat = 32'd0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.dat", dat1, 32'd0);
    chk("rst.ack", 32'(ack1), 32'd0);
    chk("rst.err", 32'(err1), 32'd0);
    chk("rst.rty", 32'(rty1), 32'd0);
    chk("rst.adr", adri1, 32'd0);
    chk("rst.tag", 32'(tagi1), 32'd0);
    chk("rst.ack3", 32'(ack3), 32'd0);
    rst_n = 1'b1;

    preload(10'h040, 32'h1500_0000);
    preload(10'h041, 32'hA5A5_0041);
    preload(10'h042, 32'h5A5A_0042);
    preload(10'h3FF, 32'hDEAD_03FF);

    // Basic fetch, misaligned, recovery, range boundaries
    fetch1("f100",  32'h0000_0100, 4'h3, 1'b1, 32'h1500_0000);
    fetch1("f102",  32'h0000_0102, 4'h5, 1'b0, 32'h0000_0000);
    fetch1("f100b", 32'h0000_0100, 4'h6, 1'b1, 32'h1500_0000);
    fetch1("f1000", 32'h0000_1000, 4'h7, 1'b0, 32'h0000_0000);
    fetch1("fFFC",  32'h0000_0FFC, 4'h8, 1'b1, 32'hDEAD_03FF);
    fetch1("fhigh", 32'hFFFF_FFFC, 4'h9, 1'b0, 32'h0000_0000);

    // Back-to-back with cycstb held; address changes after acceptance are ignored
    @(negedge clk);
    cyc1 = 1'b1;
    adr  = 32'h0000_0100;
    tag  = 4'h1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("b2b.ack", 32'(ack1), 32'((i == 2) || (i == 5) || (i == 8)));
      chk("b2b.err", 32'(err1), 32'd0);
      if (i == 2) begin
        chk("b2b.dat0", dat1, 32'h1500_0000);
        chk("b2b.adr0", adri1, 32'h0000_0100);
        chk("b2b.tag0", 32'(tagi1), 32'h1);
      end
      if (i == 5) begin
        chk("b2b.dat1", dat1, 32'hA5A5_0041);
        chk("b2b.adr1", adri1, 32'h0000_0104);
        chk("b2b.tag1", 32'(tagi1), 32'h2);
      end
      if (i == 8) begin
        chk("b2b.dat2", dat1, 32'h5A5A_0042);
        chk("b2b.adr2", adri1, 32'h0000_0108);
        chk("b2b.tag2", 32'(tagi1), 32'h3);
      end
      if (i == 0) begin
        adr = 32'h0000_0104;
        tag = 4'h2;
      end
      if (i == 3) begin
        adr = 32'h0000_0108;
        tag = 4'h3;
      end
      if (i == 7) cyc1 = 1'b0;
    end
    @(negedge clk);
    chk("b2b.quiet", 32'(ack1), 32'd0);

    // Preload write colliding with the fetch read returns the old word
    @(negedge clk);
    cyc1 = 1'b1;
    adr  = 32'h0000_0100;
    tag  = 4'hA;
    @(negedge clk);
    @(negedge clk);
    cyc1   = 1'b0;
    ld_we  = 1'b1;
    ld_adr = 10'h040;
    ld_dat = 32'hCAFE_0040;
    @(negedge clk);
    ld_we = 1'b0;
    chk("coll.ack", 32'(ack1), 32'd1);
    chk("coll.dat", dat1, 32'h1500_0000);
    fetch1("coll.re", 32'h0000_0100, 4'hB, 1'b1, 32'hCAFE_0040);

    // Three wait states: cycstb dropped during WAIT gives no response
    @(negedge clk);
    cyc3 = 1'b1;
    adr  = 32'h0000_0104;
    tag  = 4'h4;
    @(negedge clk);
    cyc3 = 1'b0;
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      chk("drop.ack", 32'(ack3), 32'd0);
      chk("drop.err", 32'(err3), 32'd0);
    end

    // Same instance then serves a normal fetch with four-cycle latency
    @(negedge clk);
    cyc3 = 1'b1;
    adr  = 32'h0000_0104;
    tag  = 4'h4;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ws3.ack", 32'(ack3), 32'(i == 4));
      chk("ws3.err", 32'(err3), 32'd0);
      if (i == 4) begin
        chk("ws3.dat", dat3, 32'hA5A5_0041);
        chk("ws3.adr", adri3, 32'h0000_0104);
        chk("ws3.tag", 32'(tagi3), 32'h4);
      end
      if (i == 3) cyc3 = 1'b0;
    end

    // Reset asserted mid-WAIT clears outputs immediately; nothing follows
    @(negedge clk);
    cyc3 = 1'b1;
    adr  = 32'h0000_0108;
    tag  = 4'h5;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst.dat", dat3, 32'd0);
    chk("mrst.adr", adri3, 32'd0);
    chk("mrst.tag", 32'(tagi3), 32'd0);
    chk("mrst.ack", 32'(ack3), 32'd0);
    chk("mrst.err", 32'(err3), 32'd0);
    chk("mrst.dat1", dat1, 32'd0);
    cyc3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mrst.noack", 32'(ack3), 32'd0);
      chk("mrst.noerr", 32'(err3), 32'd0);
    end

    // Memory contents survive reset
    fetch1("keep", 32'h0000_0108, 4'hC, 1'b1, 32'h5A5A_0042);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
